// File: rtl/commit_unit.sv
// Retires the ROB head: registered register-file writes for non-stores, and a small
// IDLE/WRITE/ACK FSM that drives the data-memory write port for stores.
module commit_unit #(
  parameter int unsigned ROB_SIZE      = 8,
  parameter int unsigned STORE_LATENCY = 2,
  // iType encoding of conditional branches; these retire without writing the register file
  parameter logic [3:0]  BRANCH_ITYPE  = 4'd4,
  localparam int         ROB_IX        = $clog2(ROB_SIZE) - 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            commit_in,
  input  logic            store_valid_in,
  input  logic [ROB_IX:0] ix_in,
  input  logic [3:0]      iType_in,
  input  logic [31:0]     value_in,
  input  logic [31:0]     dest_in,
  input  logic            flush_in,
  output logic            store_read_out,
  output logic            rf_we_out,
  output logic [4:0]      rf_addr_out,
  output logic [31:0]     rf_data_out,
  output logic [ROB_IX:0] rf_rob_ix_out,
  output logic            mem_we_out,
  output logic [31:0]     mem_addr_out,
  output logic [31:0]     mem_data_out,
  output logic            busy_out,
  output logic [31:0]     retired_count_out
);

  localparam int unsigned CntW = (STORE_LATENCY > 1) ? $clog2(STORE_LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(STORE_LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StAck
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic commit_ok;
  logic rf_write;
  logic store_start;
  logic store_done;

  // A flush masks the retiring instruction; commit wins over a simultaneous store.
  assign commit_ok   = commit_in && !flush_in;
  assign rf_write    = commit_ok && (iType_in != BRANCH_ITYPE) && (dest_in[4:0] != 5'd0);
  assign store_start = (state_q == StIdle) && store_valid_in && !commit_in && !flush_in;
  assign store_done  = (state_q == StWrite) && (cnt_q == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      store_read_out    <= 1'b0;
      rf_we_out         <= 1'b0;
      rf_addr_out       <= '0;
      rf_data_out       <= '0;
      rf_rob_ix_out     <= '0;
      mem_we_out        <= 1'b0;
      mem_addr_out      <= '0;
      mem_data_out      <= '0;
      busy_out          <= 1'b0;
      retired_count_out <= '0;
    end else begin
      // Register-file path runs independently of the store FSM.
      rf_we_out <= rf_write;
      if (commit_ok) begin
        rf_rob_ix_out <= ix_in;
        rf_addr_out   <= dest_in[4:0];
        rf_data_out   <= value_in;
      end

      // A store counts as retired on the edge that raises its acknowledge pulse.
      retired_count_out <= retired_count_out + 32'(commit_ok) + 32'(store_done);

      unique case (state_q)
        StIdle: begin
          if (store_start) begin
            mem_addr_out <= dest_in;
            mem_data_out <= value_in;
            mem_we_out   <= 1'b1;
            cnt_q        <= CntInit;
            busy_out     <= 1'b1;
            state_q      <= StWrite;
          end
        end
        StWrite: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mem_we_out     <= 1'b0;
            store_read_out <= 1'b1;
            state_q        <= StAck;
          end
        end
        StAck: begin
          // The ROB pops the store on this edge, so the next IDLE sees a fresh head.
          store_read_out <= 1'b0;
          busy_out       <= 1'b0;
          state_q        <= StIdle;
        end
        default: begin
          mem_we_out     <= 1'b0;
          store_read_out <= 1'b0;
          busy_out       <= 1'b0;
          state_q        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed and random checks of commit_unit against a cycle-offset reference model.
module tb_commit_unit;

  localparam int         L  = 2;
  localparam logic [3:0] BR = 4'd4;
  localparam logic [3:0] OP = 4'd0;

  logic        clk_in = 1'b0;
  logic        rst_in, commit_in, store_valid_in, flush_in;
  logic [2:0]  ix_in;
  logic [3:0]  iType_in;
  logic [31:0] value_in, dest_in;
  logic        store_read_out, rf_we_out, mem_we_out, busy_out;
  logic [4:0]  rf_addr_out;
  logic [31:0] rf_data_out, mem_addr_out, mem_data_out, retired_count_out;
  logic [2:0]  rf_rob_ix_out;

  commit_unit #(
    .ROB_SIZE      (8),
    .STORE_LATENCY (L),
    .BRANCH_ITYPE  (BR)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .commit_in         (commit_in),
    .store_valid_in    (store_valid_in),
    .ix_in             (ix_in),
    .iType_in          (iType_in),
    .value_in          (value_in),
    .dest_in           (dest_in),
    .flush_in          (flush_in),
    .store_read_out    (store_read_out),
    .rf_we_out         (rf_we_out),
    .rf_addr_out       (rf_addr_out),
    .rf_data_out       (rf_data_out),
    .rf_rob_ix_out     (rf_rob_ix_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_data_out      (mem_data_out),
    .busy_out          (busy_out),
    .retired_count_out (retired_count_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model: a store is described by the edge that accepted it; every output
  // is a function of the edge offset from that acceptance.
  int          edge_no = 0;
  bit          st_active = 0;
  int          st_start = 0;
  logic        m_rf_we, m_mem_we, m_sr, m_busy;
  logic [4:0]  m_rf_addr;
  logic [31:0] m_rf_data, m_mem_addr, m_mem_data, m_count;
  logic [2:0]  m_rf_ix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic step();
    int k;
    bit idle_before;
    @(posedge clk_in);
    if (rst_in) begin
      st_active = 0;
      {m_rf_we, m_mem_we, m_sr, m_busy} = '0;
      m_rf_addr = '0; m_rf_data = '0; m_rf_ix = '0;
      m_mem_addr = '0; m_mem_data = '0; m_count = '0;
    end else begin
      idle_before = !st_active || (edge_no - st_start >= L + 2);
      if (idle_before) st_active = 0;
      if (commit_in && !flush_in) begin
        m_rf_we   = (iType_in != BR) && (dest_in[4:0] != 5'd0);
        m_rf_ix   = ix_in;
        m_rf_addr = dest_in[4:0];
        m_rf_data = value_in;
        m_count   = m_count + 1;
      end else begin
        m_rf_we = 1'b0;
      end
      if (idle_before && store_valid_in && !commit_in && !flush_in) begin
        st_active  = 1;
        st_start   = edge_no;
        m_mem_addr = dest_in;
        m_mem_data = value_in;
      end
      k        = edge_no - st_start;
      m_mem_we = st_active && (k < L);
      m_sr     = st_active && (k == L);
      m_busy   = st_active && (k <= L);
      if (st_active && k == L) m_count = m_count + 1;
    end
    edge_no++;
    #1;
    chk("rf_we", 32'(rf_we_out), 32'(m_rf_we));
    chk("rf_addr", 32'(rf_addr_out), 32'(m_rf_addr));
    chk("rf_data", rf_data_out, m_rf_data);
    chk("rf_rob_ix", 32'(rf_rob_ix_out), 32'(m_rf_ix));
    chk("mem_we", 32'(mem_we_out), 32'(m_mem_we));
    chk("mem_addr", mem_addr_out, m_mem_addr);
    chk("mem_data", mem_data_out, m_mem_data);
    chk("store_read", 32'(store_read_out), 32'(m_sr));
    chk("busy", 32'(busy_out), 32'(m_busy));
    chk("retired_count", retired_count_out, m_count);
  endtask

  task automatic idle_inputs();
    commit_in = 0; store_valid_in = 0; flush_in = 0; rst_in = 0;
    ix_in = '0; iType_in = OP; value_in = '0; dest_in = '0;
  endtask

  int we_cycles, pulses, bursts;
  logic prev_we;
  int r;

  initial begin
    idle_inputs();
    rst_in = 1;
    step();
    chk("reset_count", retired_count_out, 32'd0);
    rst_in = 0;
    step();

    // 1: plain register write
    commit_in = 1; iType_in = OP; dest_in = 32'd5; value_in = 32'h1234; ix_in = 3'd3;
    step();
    commit_in = 0;
    chk("t1_we", 32'(rf_we_out), 32'd1);
    chk("t1_addr", 32'(rf_addr_out), 32'd5);
    chk("t1_data", rf_data_out, 32'h1234);
    chk("t1_ix", 32'(rf_rob_ix_out), 32'd3);
    chk("t1_count", retired_count_out, 32'd1);
    step();
    chk("t1_we_drop", 32'(rf_we_out), 32'd0);

    // 2: x0 destination and branch retire without writing
    commit_in = 1; dest_in = 32'd0; value_in = 32'h55;
    step();
    chk("t2_x0_we", 32'(rf_we_out), 32'd0);
    iType_in = BR; dest_in = 32'd9;
    step();
    chk("t2_br_we", 32'(rf_we_out), 32'd0);
    chk("t2_count", retired_count_out, 32'd3);
    idle_inputs();
    step();

    // 3: single store, held until acknowledged
    rst_in = 1; step(); rst_in = 0;
    store_valid_in = 1; dest_in = 32'h40; value_in = 32'hDEAD;
    we_cycles = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_we_out) begin
        we_cycles++;
        chk("t3_addr", mem_addr_out, 32'h40);
        chk("t3_data", mem_data_out, 32'hDEAD);
      end
      if (m_sr) begin
        pulses++;
        chk("t3_pulse_edge", 32'(i), 32'(L));
        store_valid_in = 0;
      end
    end
    chk("t3_we_cycles", 32'(we_cycles), 32'(L));
    chk("t3_pulses", 32'(pulses), 32'd1);

    // 4: back-to-back stores
    rst_in = 1; step(); rst_in = 0;
    store_valid_in = 1; dest_in = 32'h40; value_in = 32'hDEAD;
    bursts = 0; pulses = 0; prev_we = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_we_out && !prev_we) bursts++;
      prev_we = mem_we_out;
      if (m_sr) begin
        pulses++;
        if (pulses == 1) begin
          dest_in = 32'h44; value_in = 32'hBEEF;
        end else begin
          store_valid_in = 0;
        end
      end
      if (i == L + 2) chk("t4_second_addr", mem_addr_out, 32'h44);
    end
    chk("t4_bursts", 32'(bursts), 32'd2);
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_count", retired_count_out, 32'd2);

    // 5: flush mid-WRITE does not cancel; flush in IDLE blocks acceptance
    store_valid_in = 1; dest_in = 32'h80; value_in = 32'h1;
    step();
    flush_in = 1; store_valid_in = 0; dest_in = 32'hFFFF; value_in = 32'hFFFF;
    step(); step();
    chk("t5_ack", 32'(store_read_out), 32'd1);
    chk("t5_latched", mem_addr_out, 32'h80);
    store_valid_in = 1;
    step(); step(); step();
    chk("t5_no_write", 32'(mem_we_out), 32'd0);
    chk("t5_idle", 32'(busy_out), 32'd0);
    flush_in = 0; store_valid_in = 0;
    step();

    // 6: reset in the middle of a store
    store_valid_in = 1; dest_in = 32'hC0; value_in = 32'h77;
    step(); step();
    rst_in = 1;
    step();
    chk("t6_we", 32'(mem_we_out), 32'd0);
    chk("t6_busy", 32'(busy_out), 32'd0);
    chk("t6_count", retired_count_out, 32'd0);
    idle_inputs();
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r              = int'($urandom_range(0, 99));
      commit_in      = (r < 30) || (r >= 95);
      store_valid_in = (r >= 30 && r < 70) || (r >= 95);
      flush_in       = ($urandom_range(0, 9) == 0);
      rst_in         = ($urandom_range(0, 99) == 0);
      iType_in       = 4'($urandom_range(0, 7));
      ix_in          = 3'($urandom_range(0, 7));
      dest_in        = $urandom;
      value_in       = $urandom;
      if ($urandom_range(0, 5) == 0) dest_in[4:0] = 5'd0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
